instr_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the instruction decoder. Holds the program counter, issues word fetches to instruction memory, and buffers returned instructions in a 2-entry queue. Presents instruction/PC pairs to decode over a valid/ready handshake. Redirects the PC on taken branches/jumps resolved downstream, discarding any fetches in flight.

---
 rtl/instr_fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem requests, 2-entry queue toward decode.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
`timescale 1ns/1ps
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {StRun, StWait, StDrain, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        fault_q, fault_d;
  logic        pend_q, pend_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] q0_inst_q, q0_inst_d, q0_pc_q, q0_pc_d;
  logic [31:0] q1_inst_q, q1_inst_d, q1_pc_q, q1_pc_d;

  logic       resp_acc;
  logic       bypass;
  logic       deq;
  logic       push;
  logic [1:0] cnt_after_pop;
  logic       pending_after;
  logic       drain_done;

  // A response is only meaningful for the live request and is lost to a same-cycle redirect.
  assign resp_acc = imem_rvalid && (state_q == StWait) && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_acc && (cnt_q == 2'd0);
`else
  assign bypass = 1'b0;
`endif

  assign inst_valid    = (cnt_q != 2'd0) || bypass;
  assign inst          = bypass ? imem_rdata : q0_inst_q;
  assign inst_pc       = bypass ? addr_q : q0_pc_q;

  assign deq           = (cnt_q != 2'd0) && inst_ready && !redirect_valid;
  assign push          = resp_acc && !(bypass && inst_ready);
  assign cnt_after_pop = cnt_q - {1'b0, deq};

  assign imem_req      = req_q;
  assign imem_addr     = addr_q;
  assign fetch_fault   = fault_q;

  // Queue: head shifts out first, then the new entry lands in the first free slot.
  always_comb begin
    q0_inst_d = q0_inst_q;
    q0_pc_d   = q0_pc_q;
    q1_inst_d = q1_inst_q;
    q1_pc_d   = q1_pc_q;
    if (deq) begin
      q0_inst_d = q1_inst_q;
      q0_pc_d   = q1_pc_q;
    end
    if (push) begin
      if (cnt_after_pop == 2'd0) begin
        q0_inst_d = imem_rdata;
        q0_pc_d   = addr_q;
      end else begin
        q1_inst_d = imem_rdata;
        q1_pc_d   = addr_q;
      end
    end
    cnt_d = cnt_after_pop + {1'b0, push};
    if (redirect_valid) begin
      cnt_d = 2'd0;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = 1'b0;
    addr_d     = addr_q;
    pend_d     = pend_q;
    drain_done = 1'b0;
    // Whether a request will still be in flight once this cycle is over.
    pending_after = ((state_q == StWait) || (state_q == StDrain) ||
                     ((state_q == StHalt) && pend_q)) && !imem_rvalid;

    if (redirect_valid) begin
      pc_d   = redirect_pc;
      pend_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = StHalt;
        pend_d  = pending_after;
      end else if (pending_after) begin
        state_d = StDrain;
      end else begin
        state_d = StRun;
      end
    end else begin
      unique case (state_q)
        StRun:   ;
        StWait:  if (imem_rvalid) state_d = StRun;
        StDrain: begin
          if (imem_rvalid) begin
            state_d    = StRun;
            drain_done = 1'b1;
          end
        end
        StHalt:  if (imem_rvalid) pend_d = 1'b0;
        default: ;
      endcase
    end

    if ((state_d == StRun) && !drain_done && (cnt_d != 2'd2)) begin
      req_d   = 1'b1;
      addr_d  = pc_d;
      pc_d    = pc_d + 32'd4;
      state_d = StWait;
    end

    fault_d = (state_d == StHalt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      addr_q    <= RESET_PC;
      fault_q   <= 1'b0;
      pend_q    <= 1'b0;
      cnt_q     <= 2'd0;
      q0_inst_q <= 32'h0;
      q0_pc_q   <= 32'h0;
      q1_inst_q <= 32'h0;
      q1_pc_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      fault_q   <= fault_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      q0_inst_q <= q0_inst_d;
      q0_pc_q   <= q0_pc_d;
      q1_inst_q <= q1_inst_d;
      q1_pc_q   <= q1_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level model plus directed literal checks.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_req, imem_rvalid, redirect_valid, inst_valid, inst_ready, fetch_fault;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;

  logic        rst2, req2, rvalid2, valid2, fault2;
  logic [31:0] addr2, rdata2, inst2, pc2;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .fetch_fault(fetch_fault)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .inst_valid(valid2), .inst(inst2), .inst_pc(pc2),
    .inst_ready(1'b0), .fetch_fault(fault2)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory: one pending request, response after 1..lat_max cycles.
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_max;

  task automatic step(input logic rst_v);
    @(posedge clk);
    #1;
    rst            = rst_v;
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b0;
    if (rst_v) begin
      mem_pend = 1'b0;
    end else begin
      if (mem_pend) begin
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(mem_addr);
          mem_pend    = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      if (imem_req) begin
        mem_pend = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = $urandom_range(0, lat_max - 1);
      end
    end
  endtask

  // Reference model: what the outputs must be after each edge.
  typedef struct packed {logic [31:0] ins; logic [31:0] pc;} ent_t;
  ent_t        fifo[$];
  logic [31:0] m_pc, m_out_addr, e_addr;
  bit          m_out, m_disc, m_halt, e_req, e_rst;
  bit          started = 1'b0;

  always @(posedge clk) begin : model
    bit   allow;
    ent_t e;
    if (rst) begin
      fifo.delete();
      m_pc   = 32'h0;
      m_out  = 1'b0;
      m_disc = 1'b0;
      m_halt = 1'b0;
      e_req  = 1'b0;
      e_addr = 32'h0;
      e_rst  = 1'b1;
    end else begin
      e_rst = 1'b0;
      allow = 1'b1;
      if (redirect_valid) begin
        m_disc = (m_out || m_disc) && !imem_rvalid;
        m_out  = 1'b0;
        fifo.delete();
        m_pc   = redirect_pc;
        m_halt = (redirect_pc % 4) != 0;
      end else begin
        if (fifo.size() != 0 && inst_ready) void'(fifo.pop_front());
        if (imem_rvalid && m_out) begin
          e.ins = imem_rdata;
          e.pc  = m_out_addr;
          fifo.push_back(e);
          m_out = 1'b0;
        end else if (imem_rvalid && m_disc) begin
          m_disc = 1'b0;
          allow  = 1'b0;
        end
      end
      e_req = allow && !m_halt && !m_out && !m_disc && (fifo.size() < 2);
      if (e_req) begin
        e_addr     = m_pc;
        m_out_addr = m_pc;
        m_pc       = m_pc + 32'd4;
        m_out      = 1'b1;
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chkb("imem_req", imem_req, e_req);
      if (e_req || e_rst) chk("imem_addr", imem_addr, e_addr);
      chkb("inst_valid", inst_valid, fifo.size() != 0);
      if (fifo.size() != 0) begin
        chk("inst", inst, fifo[0].ins);
        chk("inst_pc", inst_pc, fifo[0].pc);
      end else if (e_rst) begin
        chk("inst_rst", inst, 32'h0);
        chk("inst_pc_rst", inst_pc, 32'h0);
      end
      chkb("fetch_fault", fetch_fault, m_halt);
    end
  end

  initial begin
    int  n_req;
    bit  found;
    rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; inst_ready = 1'b1;
    rst2 = 1'b1; rvalid2 = 1'b0; rdata2 = 32'h0;
    mem_pend = 1'b0; mem_cnt = 0; mem_addr = 32'h0; lat_max = 1;

    // Reset and streaming with 1-cycle memory.
    repeat (3) step(1'b1);
    step(1'b0);
    chkb("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chkb("rst_valid", inst_valid, 1'b0);
    chkb("rst_fault", fetch_fault, 1'b0);
    step(1'b0);
    chkb("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);
    step(1'b0);
    chkb("first_gap", imem_req, 1'b0);
    chkb("first_gap_valid", inst_valid, 1'b0);
    step(1'b0);
    chkb("second_req", imem_req, 1'b1);
    chk("second_addr", imem_addr, 32'h4);
    chkb("first_valid", inst_valid, 1'b1);
    chk("first_pc", inst_pc, 32'h0);
    chk("first_inst", inst, mem_word(32'h0));
    repeat (20) step(1'b0);

    // Decode stalled: exactly two requests fill the queue.
    step(1'b1);
    step(1'b1);
    inst_ready = 1'b0;
    step(1'b0);
    n_req = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      if (imem_req) n_req++;
    end
    chk("stall_req_count", n_req, 32'd2);
    chkb("stall_valid", inst_valid, 1'b1);
    chk("stall_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    step(1'b0);
    chk("release_pc1", inst_pc, 32'h4);
    repeat (10) step(1'b0);

    // Redirect while a request is outstanding.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0);
      found = imem_req;
    end
    chkb("wait_req_before_redirect", found, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step(1'b0);
    chkb("redirect_flush", inst_valid, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0);
      found = inst_valid;
    end
    chkb("wait_valid_after_redirect", found, 1'b1);
    chk("redirect_first_pc", inst_pc, 32'h100);

    // Redirect in the same cycle as a response.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0);
      found = imem_rvalid;
    end
    chkb("wait_rvalid", found, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step(1'b0);
    chkb("same_cycle_req", imem_req, 1'b1);
    chk("same_cycle_addr", imem_addr, 32'h100);

    // Misaligned redirect halts until an aligned one.
    inst_ready = 1'b0;
    repeat (12) step(1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    step(1'b0);
    chkb("halt_fault", fetch_fault, 1'b1);
    chkb("halt_no_req", imem_req, 1'b0);
    repeat (5) begin
      step(1'b0);
      chkb("halt_fault_held", fetch_fault, 1'b1);
      chkb("halt_req_held", imem_req, 1'b0);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step(1'b0);
    chkb("unhalt_fault", fetch_fault, 1'b0);
    chkb("unhalt_req", imem_req, 1'b1);
    chk("unhalt_addr", imem_addr, 32'h200);
    inst_ready = 1'b1;

    // Second instance: PC wrap and mid-fetch reset.
    rst2 = 1'b0;
    step(1'b0);
    chkb("wrap_req0", req2, 1'b1);
    chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
    step(1'b0);
    rvalid2 = 1'b1;
    rdata2  = 32'h1357_9BDF;
    chkb("wrap_gap", req2, 1'b0);
    step(1'b0);
    rvalid2 = 1'b0;
    chkb("wrap_req1", req2, 1'b1);
    chk("wrap_addr1", addr2, 32'h0);
    chkb("wrap_valid", valid2, 1'b1);
    chk("wrap_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_inst", inst2, 32'h1357_9BDF);
    chkb("wrap_fault", fault2, 1'b0);
    rst2 = 1'b1;
    step(1'b0);
    chkb("midrst_req", req2, 1'b0);
    chk("midrst_addr", addr2, 32'hFFFF_FFFC);
    chkb("midrst_valid", valid2, 1'b0);
    chk("midrst_inst", inst2, 32'h0);
    chk("midrst_pc", pc2, 32'h0);
    chkb("midrst_fault", fault2, 1'b0);

    // Random traffic against the model.
    lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0);
      inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom & 32'h0000_0FFC;
        case ($urandom_range(0, 5))
          0: redirect_pc[1:0] = 2'($urandom_range(1, 3));
          1: redirect_pc = 32'hFFFF_FFF8;
          default: ;
        endcase
      end
    end
    step(1'b0);
    step(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
